// File: rtl/jt51_pkg.sv
// Shared jt51 constants and phase-generator stage bundles.
// Pulled in by the phase accumulator and its ring store.
package jt51_pkg;

    localparam int SLOTS   = 32;
    localparam int ACC_W   = 20;
    localparam int PHINC_W = 17;
    localparam int PH_W    = 10;
    localparam int ADDR_W  = 5;
    localparam int LO_W    = 8;

    typedef struct packed {
        logic [PH_W-1:0]   ph;
        logic [ADDR_W-1:0] slot;
    } pg_s1_t;

    typedef struct packed {
        logic              sign;
        logic [LO_W-1:0]   phlo;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] slot;
    } pg_s2_t;

    // Fold a 10-bit phase onto the quarter-wave table.
    function automatic pg_s2_t pg_mirror(input pg_s1_t s);
        pg_s2_t          r;
        logic [LO_W-1:0] m;
        m      = s.ph[8] ? ~s.ph[LO_W-1:0] : s.ph[LO_W-1:0];
        r.sign = s.ph[PH_W-1];
        r.phlo = m;
        r.addr = m[ADDR_W:1];
        r.slot = s.slot;
        return r;
    endfunction

endpackage

// File: rtl/jt51_pg_ring.sv
// Width x depth shift register with clock enable and async clear.
// The tail word is the oldest entry, presented back to the accumulator.
module jt51_pg_ring
    import jt51_pkg::*;
#(
    parameter int W     = ACC_W,
    parameter int DEPTH = SLOTS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cen,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (cen) begin
            r_mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign dout = r_mem[DEPTH-1];

endmodule

// File: rtl/jt51_pg_acc.sv
// Per-slot phase accumulator with phase modulation and a two-stage
// quarter-wave address pipeline feeding the sine ROM.
module jt51_pg_acc
    import jt51_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cen,
    input  logic               zero,
    input  logic [PHINC_W-1:0] phinc,
    input  logic               keyon,
    input  logic [PH_W-1:0]    pm,
    output logic [PH_W-1:0]    ph,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic [LO_W-1:0]    phlo,
    output logic               sign,
    output logic [ADDR_W-1:0]  slot,
    output logic               valid
);

    logic [ACC_W-1:0]  w_acc;
    logic [ACC_W-1:0]  w_next;
    logic [ADDR_W-1:0] w_slot_in;
    pg_s1_t            w_s1;

    logic [ADDR_W-1:0] r_cnt;
    pg_s1_t            r_s1;
    pg_s2_t            r_s2;
    logic              r_v1;
    logic              r_valid;

    jt51_pg_ring #(
        .W     (ACC_W),
        .DEPTH (SLOTS)
    ) u_ring (
        .clk   (clk),
        .rst_n (rst_n),
        .cen   (cen),
        .din   (w_next),
        .dout  (w_acc)
    );

    always_comb begin
        w_slot_in = zero ? '0 : r_cnt;
        w_next    = '0;
        if (!keyon) begin
            w_next = w_acc + {{(ACC_W-PHINC_W){1'b0}}, phinc};
        end
        w_s1.ph   = w_next[ACC_W-1:ACC_W-PH_W] + pm;
        w_s1.slot = w_slot_in;
    end

    // Slot label and valid flag track the data through both stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_s1    <= '0;
            r_s2    <= '0;
            r_v1    <= 1'b0;
            r_valid <= 1'b0;
        end else if (cen) begin
            r_cnt   <= w_slot_in + 1'b1;
            r_s1    <= w_s1;
            r_s2    <= pg_mirror(r_s1);
            r_v1    <= 1'b1;
            r_valid <= r_v1;
        end
    end

    assign ph       = r_s1.ph;
    assign rom_addr = r_s2.addr;
    assign phlo     = r_s2.phlo;
    assign sign     = r_s2.sign;
    assign slot     = r_s2.slot;
    assign valid    = r_valid;

endmodule

// File: tb/tb_jt51_pg_acc.sv
// Scoreboard bench for the phase accumulator: a ring model predicts
// stage-1 phase and stage-2 ROM fields for every cen.
module tb_jt51_pg_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b0;
    logic        zero = 1'b0;
    logic [16:0] phinc = '0;
    logic        keyon = 1'b0;
    logic [9:0]  pm = '0;
    logic [9:0]  ph;
    logic [4:0]  rom_addr;
    logic [7:0]  phlo;
    logic        sign;
    logic [4:0]  slot;
    logic        valid;

    jt51_pg_acc dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .zero     (zero),
        .phinc    (phinc),
        .keyon    (keyon),
        .pm       (pm),
        .ph       (ph),
        .rom_addr (rom_addr),
        .phlo     (phlo),
        .sign     (sign),
        .slot     (slot),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] ph;
        logic [4:0] slot;
        logic       sign;
        logic [7:0] phlo;
        logic [4:0] rom;
    } exp_t;

    exp_t        sb[$];
    exp_t        last;
    logic [19:0] m_acc [32];
    logic [4:0]  m_pos;
    logic [4:0]  m_cnt;
    int          n_steps;
    int          n_chk = 0;
    int          n_err = 0;

    logic [16:0] pinc [32];
    logic        pkey [32];
    logic [9:0]  ppm  [32];
    logic [9:0]  g_ph [32];
    logic [7:0]  g_lo [32];
    logic [4:0]  g_ra [32];
    logic        g_sg [32];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_acc[i] = '0;
        m_pos   = '0;
        m_cnt   = '0;
        n_steps = 0;
        last    = '0;
        sb.delete();
    endtask

    task automatic check_s2();
        check("slot", 32'(slot), 32'(last.slot));
        check("sign", 32'(sign), 32'(last.sign));
        check("phlo", 32'(phlo), 32'(last.phlo));
        check("rom_addr", 32'(rom_addr), 32'(last.rom));
        check("valid", 32'(valid), 32'(n_steps >= 2));
    endtask

    task automatic step(input logic z, input logic [16:0] inc,
                        input logic k, input logic [9:0] p);
        exp_t        e;
        logic [4:0]  s;
        logic [19:0] a;
        logic [7:0]  m;
        zero  = z;
        phinc = inc;
        keyon = k;
        pm    = p;
        cen   = 1'b1;
        s = z ? 5'd0 : m_cnt;
        a = k ? 20'd0 : m_acc[m_pos] + {3'b000, inc};
        m_acc[m_pos] = a;
        m_pos  = m_pos + 5'd1;
        m_cnt  = s + 5'd1;
        e.ph   = a[19:10] + p;
        e.slot = s;
        e.sign = e.ph[9];
        m      = e.ph[8] ? ~e.ph[7:0] : e.ph[7:0];
        e.phlo = m;
        e.rom  = m[5:1];
        sb.push_back(e);
        n_steps++;
        @(posedge clk);
        #1;
        cen = 1'b0;
        check("ph", 32'(ph), 32'(sb[$].ph));
        if (sb.size() > 1) last = sb.pop_front();
        check_s2();
    endtask

    task automatic run_pass();
        for (int s = 0; s < 32; s++) begin
            step(1'b0, pinc[s], pkey[s], ppm[s]);
            g_ph[s] = ph;
            if (valid) begin
                g_lo[slot] = phlo;
                g_ra[slot] = rom_addr;
                g_sg[slot] = sign;
            end
        end
    endtask

    task automatic clear_pass();
        for (int i = 0; i < 32; i++) begin
            pinc[i] = '0;
            pkey[i] = 1'b0;
            ppm[i]  = '0;
        end
    endtask

    initial begin
        model_reset();
        clear_pass();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ph", 32'(ph), 0);
        check("rst_valid", 32'(valid), 0);
        check_s2();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Build up slots 0/3/5/7 over eight passes.
        for (int p = 0; p < 8; p++) begin
            clear_pass();
            if (p < 2) pinc[0] = 17'd1024;
            if (p < 4) pinc[3] = 17'h1FF00;
            pinc[5] = 17'h1FF80;
            pinc[7] = 17'd128000;
            run_pass();
            if (p == 0) check("inc_p0", 32'(g_ph[0]), 1);
            if (p == 1) check("inc_p1", 32'(g_ph[0]), 2);
            if (p == 3) check("acc_7fc00", 32'(g_ph[3]), 32'h1FF);
        end
        check("acc_ffc00", 32'(g_ph[5]), 32'h3FF);
        check("acc_1000", 32'(g_ph[7]), 1000);

        clear_pass();
        pkey[3] = 1'b1;
        pinc[3] = 17'd500;
        pinc[5] = 17'd1024;
        ppm[7]  = 10'd100;
        run_pass();
        check("keyon_ph", 32'(g_ph[3]), 0);
        check("wrap_acc", 32'(g_ph[5]), 0);
        check("wrap_pm", 32'(g_ph[7]), 76);

        clear_pass();
        pinc[3] = 17'd2048;
        ppm[10] = 10'h100;
        ppm[11] = 10'h2C3;
        run_pass();
        check("keyon_next", 32'(g_ph[3]), 2);
        check("mir_ph100", 32'(g_ph[10]), 32'h100);
        check("mir_sg0", 32'(g_sg[10]), 0);
        check("mir_lo0", 32'(g_lo[10]), 32'hFF);
        check("mir_ra0", 32'(g_ra[10]), 31);
        check("mir_sg1", 32'(g_sg[11]), 1);
        check("mir_lo1", 32'(g_lo[11]), 32'hC3);
        check("mir_ra1", 32'(g_ra[11]), 1);

        for (int i = 0; i < 10; i++) begin
            zero  = 1'($urandom_range(0, 1));
            keyon = 1'($urandom_range(0, 1));
            phinc = 17'($urandom);
            pm    = 10'($urandom);
            @(posedge clk);
            #1;
            check("hold_ph", 32'(ph), 32'(sb[$].ph));
            check_s2();
        end

        for (int i = 0; i < 17; i++) step(1'b0, 17'd3000, 1'b0, 10'd0);
        step(1'b1, 17'd0, 1'b0, 10'd0);
        step(1'b0, 17'd0, 1'b0, 10'd0);
        check("sync_slot", 32'(slot), 0);
        for (int i = 0; i < 5; i++) step(1'b0, 17'd700, 1'b0, 10'd3);

        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_ph", 32'(ph), 0);
        check("mrst_lo", 32'(phlo), 0);
        check("mrst_ra", 32'(rom_addr), 0);
        check("mrst_sg", 32'(sign), 0);
        check("mrst_slot", 32'(slot), 0);
        check("mrst_valid", 32'(valid), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_pass();
        for (int i = 0; i < 32; i++) pinc[i] = 17'(i * 1024);
        run_pass();
        check("rst_s0", 32'(g_ph[0]), 0);
        check("rst_s3", 32'(g_ph[3]), 3);
        check("rst_s31", 32'(g_ph[31]), 31);
        run_pass();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/jt51_pg_acc.md
JT51_PG_ACC -- requirements
Module: jt51_pg_acc

Interface
REQ-001 SHALL have clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-002 SHALL have rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have cen, input, 1, clock enable; state advances only on clk edges with cen=1.
REQ-004 SHALL have zero, input, 1, slot-sync strobe; high marks the current input slot as slot 0.
REQ-005 SHALL have phinc, input, 17, unsigned phase increment for the current slot.
REQ-006 SHALL have keyon, input, 1, restart the current slot's phase.
REQ-007 SHALL have pm, input, 10, phase-modulation offset for the current slot, added modulo 1024.
REQ-008 SHALL have ph, output, 10, stage-1 modulated phase.
REQ-009 SHALL have rom_addr, output, 5, stage-2 quarter-wave sine-ROM address.
REQ-010 SHALL have phlo, output, 8, stage-2 mirrored quarter-wave fraction.
REQ-011 SHALL have sign, output, 1, stage-2 half-wave sign, equal to ph bit 9.
REQ-012 SHALL have slot, output, 5, slot index aligned with the stage-2 outputs.
REQ-013 SHALL have valid, output, 1, high once stage-2 outputs are meaningful.

Function
REQ-014 SHALL hold 32 per-slot 20-bit accumulators in a 32-deep ring; each cen rotates the ring by one slot.
REQ-015 SHALL compute the next value of the current slot as 0 when keyon=1 (phinc ignored), else acc + zero-extended phinc modulo 2^20, and SHALL write it back into the ring.
REQ-016 SHALL register ph = (next acc bits 19:10 + pm) modulo 1024 on the same cen, giving ph a latency of 1 cen.
REQ-017 SHALL register, on the following cen, sign = ph[9]; phlo = ph[7:0] when ph[8]=0, else the bitwise inverse of ph[7:0]; rom_addr = mirrored bits 5:1, giving a latency of 2 cens.
REQ-018 SHALL maintain an internal 5-bit slot counter that increments modulo 32 per cen; zero=1 with cen forces the input slot to 0, resynchronising at any count.
REQ-019 SHALL delay the slot index by 2 cens so that slot matches rom_addr, phlo and sign.
REQ-020 SHALL raise valid after the second cen following reset and hold it high until the next reset.
REQ-021 SHALL hold all state and outputs unchanged while cen=0, regardless of the other inputs.
REQ-022 SHALL wrap accumulator and pm additions silently, with no saturation or flag.

Reset
REQ-023 SHALL clear all 32 accumulators, ph, rom_addr, phlo, sign, slot, valid and the slot counter to 0 asynchronously on rst_n low, including mid-rotation.
REQ-024 SHALL resume from slot 0 with cleared accumulators on the first cen after rst_n deasserts.

Structure
REQ-025 SHALL place the constants SLOTS=32, ACC_W=20, PHINC_W=17, PH_W=10 and ADDR_W=5 in the shared jt51 package.
REQ-026 SHALL implement the ring as a sub-module jt51_pg_ring: a parameterised width×depth shift register with cen and async clear.
REQ-027 SHALL drive rom_addr directly into jt51_phrom addr, which adds 1 further cen of latency.

Verification
REQ-028 SHALL test increment: phinc=1024 in slot 0 only, pm=0 -> ph=1 one cen later; slot 0 ph=2 on the next pass, 32 cens later.
REQ-029 SHALL test keyon: slot 3 acc=0x7FC00, keyon=1 with phinc=500 -> that slot's ph=0, and the next pass adds only phinc.
REQ-030 SHALL test wrap: slot acc=0xFFC00, phinc=1024 -> acc=0, ph=0; separately acc bits 19:10=1000 with pm=100 -> ph=76.
REQ-031 SHALL test mirror: ph=0x100 -> sign=0, phlo=0xFF, rom_addr=31; ph=0x2C3 -> sign=1, phlo=0xC3, rom_addr=1.
REQ-032 SHALL test hold and sync: cen low 10 cycles -> outputs frozen; zero pulsed at count 17 -> slot output reads 0 two cens later.
REQ-033 SHALL test reset mid-op: rst_n low during rotation with nonzero accumulators -> all outputs 0 immediately, valid=0, and all slots restart from 0.
